// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use interlock,
// branch flush, data-memory wait, orderly drain-then-halt and timeout halt.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W           = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES    = 4,
  parameter int unsigned MEM_TIMEOUT     = 255,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_valid_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             halt_req_i,
  output logic [3:0]       pipe_enable_o,
  output logic [3:0]       pipe_stall_o,
  output logic [3:0]       pipe_flush_o,
  output logic [3:0]       pipe_halt_o,
  output logic             pc_hold_o,
  output logic             pc_redirect_o,
  output logic             halted_o,
  output logic             mem_timeout_o
);

  typedef enum logic [2:0] {
    S_RUN, S_LOAD_STALL, S_MEM_WAIT, S_DRAIN, S_HALTED
  } state_e;

  state_e           state_q, state_d, saved_q, saved_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt, wait_cnt;
  logic             halt_pend_q, halt_pend_d, timeout_q, timeout_d;

  logic             hazard, memwait, branch, pend_now;
  logic [3:0]       en_c, stall_c, flush_c, halt_c;
  logic             hold_c, redir_c, halted_c;

  assign hazard = ex_valid_i & ex_is_load_i & (ex_rd_i != '0) & id_valid_i &
                  ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                   (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
  assign memwait  = mem_req_i & ~mem_ready_i;
  assign branch   = ex_valid_i & ex_branch_taken_i;
  assign pend_now = halt_pend_q | halt_req_i;
  assign wait_cnt = (state_q == S_MEM_WAIT) ? cnt_q + CNT_W'(1) : CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      saved_q     <= S_RUN;
      cnt_q       <= '0;
      saved_cnt_q <= '0;
      halt_pend_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      saved_cnt_q <= saved_cnt_d;
      halt_pend_q <= halt_pend_d;
      timeout_q   <= timeout_d;
    end
  end

  // The cycle memory releases is spent as the saved state with its frozen count.
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    cnt_d       = cnt_q;
    saved_cnt_d = saved_cnt_q;
    halt_pend_d = halt_pend_q | halt_req_i;
    timeout_d   = timeout_q;
    en_c        = 4'b1111;
    stall_c     = 4'b0000;
    flush_c     = 4'b0000;
    halt_c      = 4'b0000;
    hold_c      = 1'b0;
    redir_c     = 1'b0;
    halted_c    = 1'b0;
    eff_state   = state_q;
    eff_cnt     = cnt_q;
    if (state_q == S_MEM_WAIT) begin
      eff_state = saved_q;
      eff_cnt   = saved_cnt_q;
    end

    if (state_q == S_HALTED) begin
      en_c     = 4'b0000;
      halt_c   = 4'b1111;
      hold_c   = 1'b1;
      halted_c = 1'b1;
    end else if (memwait) begin
      stall_c = 4'b0111;
      flush_c = 4'b1000;
      hold_c  = 1'b1;
      if (state_q != S_MEM_WAIT) begin
        saved_d     = state_q;
        saved_cnt_d = cnt_q;
      end
      cnt_d   = wait_cnt;
      state_d = S_MEM_WAIT;
      if (wait_cnt >= CNT_W'(MEM_TIMEOUT)) begin
        timeout_d = 1'b1;
        state_d   = S_HALTED;
      end
    end else begin
      state_d = eff_state;
      cnt_d   = eff_cnt;
      unique case (eff_state)
        S_RUN, S_LOAD_STALL: begin
          if (branch) begin
            flush_c = 4'b0011;
            redir_c = 1'b1;
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (eff_state == S_LOAD_STALL) begin
            stall_c = 4'b0001;
            flush_c = 4'b0010;
            hold_c  = 1'b1;
            if (eff_cnt <= CNT_W'(1)) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = eff_cnt - CNT_W'(1);
            end
          end else if (hazard) begin
            stall_c = 4'b0001;
            flush_c = 4'b0010;
            hold_c  = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_d = S_LOAD_STALL;
              cnt_d   = CNT_W'(LOAD_USE_CYCLES - 1);
            end
          end else if (pend_now) begin
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          hold_c  = 1'b1;
          flush_c = branch ? 4'b0011 : 4'b0001;
          if (eff_cnt <= CNT_W'(1)) begin
            state_d = S_HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = eff_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign pipe_enable_o = reset ? 4'b0000 : en_c;
  assign pipe_stall_o  = reset ? 4'b0000 : stall_c;
  assign pipe_flush_o  = reset ? 4'b0000 : flush_c;
  assign pipe_halt_o   = reset ? 4'b0000 : halt_c;
  assign pc_hold_o     = ~reset & hold_c;
  assign pc_redirect_o = ~reset & redir_c;
  assign halted_o      = ~reset & halted_c;
  assign mem_timeout_o = ~reset & timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, multi-cycle sequences
// and randomized traffic against a counter-based reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned LU    = 1;
  localparam int unsigned DRAIN = 4;
  localparam int unsigned TO    = 4;

  typedef struct packed {
    logic             id_valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             u1;
    logic             u2;
    logic             ex_valid;
    logic [REG_W-1:0] rd;
    logic             ld;
    logic             br;
    logic             mreq;
    logic             mrdy;
    logic             hreq;
  } in_t;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] st;
    logic [3:0] fl;
    logic [3:0] hl;
    logic       hold;
    logic       redir;
    logic       hlt;
    logic       to;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load;
  logic             ex_branch_taken, mem_req, mem_ready, halt_req;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic [3:0]       pipe_enable, pipe_stall, pipe_flush, pipe_halt;
  logic             pc_hold, pc_redirect, halted, mem_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W(REG_W), .LOAD_USE_CYCLES(LU), .DRAIN_CYCLES(DRAIN),
    .MEM_TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load),
    .ex_branch_taken_i(ex_branch_taken), .mem_req_i(mem_req),
    .mem_ready_i(mem_ready), .halt_req_i(halt_req),
    .pipe_enable_o(pipe_enable), .pipe_stall_o(pipe_stall),
    .pipe_flush_o(pipe_flush), .pipe_halt_o(pipe_halt),
    .pc_hold_o(pc_hold), .pc_redirect_o(pc_redirect),
    .halted_o(halted), .mem_timeout_o(mem_timeout)
  );

  function automatic out_t mk(logic [3:0] en, logic [3:0] st, logic [3:0] fl,
                              logic [3:0] hl, logic hold, logic redir,
                              logic hlt, logic to);
    out_t o;
    o = {en, st, fl, hl, hold, redir, hlt, to};
    return o;
  endfunction

  out_t O_ZERO, O_DEF, O_LU, O_BR, O_MW, O_DR, O_DRBR, O_HLT, O_HLT_TO;

  function automatic in_t in_idle();
    in_t r;
    r = '0;
    return r;
  endfunction

  function automatic in_t in_lu(logic [REG_W-1:0] rd, logic [REG_W-1:0] rs2);
    in_t r;
    r = '0;
    r.id_valid = 1'b1; r.u2 = 1'b1; r.rs2 = rs2;
    r.ex_valid = 1'b1; r.ld = 1'b1; r.rd = rd;
    return r;
  endfunction

  function automatic in_t in_br();
    in_t r;
    r = '0;
    r.ex_valid = 1'b1; r.br = 1'b1;
    return r;
  endfunction

  function automatic in_t in_mw();
    in_t r;
    r = '0;
    r.mreq = 1'b1;
    return r;
  endfunction

  function automatic in_t in_halt();
    in_t r;
    r = '0;
    r.hreq = 1'b1;
    return r;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r.id_valid = ($urandom_range(0, 9) < 8);
    r.rs1      = REG_W'($urandom_range(0, 3));
    r.rs2      = REG_W'($urandom_range(0, 3));
    r.u1       = ($urandom_range(0, 1) == 1);
    r.u2       = ($urandom_range(0, 1) == 1);
    r.ex_valid = ($urandom_range(0, 9) < 8);
    r.rd       = REG_W'($urandom_range(0, 3));
    r.ld       = ($urandom_range(0, 1) == 1);
    r.br       = ($urandom_range(0, 4) == 0);
    r.mreq     = ($urandom_range(0, 3) == 0);
    r.mrdy     = ($urandom_range(0, 9) < 6);
    r.hreq     = ($urandom_range(0, 39) == 0);
    return r;
  endfunction

  task automatic apply(input in_t x);
    id_valid = x.id_valid; id_rs1 = x.rs1; id_rs2 = x.rs2;
    id_uses_rs1 = x.u1; id_uses_rs2 = x.u2;
    ex_valid = x.ex_valid; ex_rd = x.rd; ex_is_load = x.ld;
    ex_branch_taken = x.br; mem_req = x.mreq; mem_ready = x.mrdy;
    halt_req = x.hreq;
  endtask

  task automatic check(input string nm, input out_t exp);
    out_t act;
    act = {pipe_enable, pipe_stall, pipe_flush, pipe_halt,
           pc_hold, pc_redirect, halted, mem_timeout};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  // Reference model: separate down-counters per activity; a memory wait simply
  // leaves the drain and stall counters untouched.
  bit m_halted, m_to, m_pend, m_draining;
  int m_wait, m_drain_left, m_ls_left;

  task automatic model_reset();
    m_halted = 0; m_to = 0; m_pend = 0; m_draining = 0;
    m_wait = 0; m_drain_left = 0; m_ls_left = 0;
  endtask

  task automatic model_step(input in_t x, output out_t e);
    bit mw, br, hz, pend_now;
    mw = x.mreq && !x.mrdy;
    br = x.ex_valid && x.br;
    hz = x.ex_valid && x.ld && (x.rd != 0) && x.id_valid &&
         ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
    e = O_DEF;
    if (m_halted) begin
      e = m_to ? O_HLT_TO : O_HLT;
    end else begin
      pend_now = m_pend || x.hreq;
      m_pend   = pend_now;
      if (mw) begin
        e = O_MW;
        m_wait++;
        if (m_wait >= int'(TO)) begin
          m_halted = 1; m_to = 1;
        end
      end else begin
        m_wait = 0;
        if (m_draining) begin
          e = br ? O_DRBR : O_DR;
          m_drain_left--;
          if (m_drain_left <= 0) m_halted = 1;
        end else if (br) begin
          e = O_BR;
          m_ls_left = 0;
        end else if (m_ls_left > 0) begin
          e = O_LU;
          m_ls_left--;
        end else if (hz) begin
          e = O_LU;
          m_ls_left = int'(LU) - 1;
        end else if (pend_now) begin
          m_draining = 1;
          m_drain_left = int'(DRAIN);
        end
      end
    end
  endtask

  task automatic cycle(input in_t x, input out_t e, input string nm);
    @(negedge clk);
    apply(x);
    #1;
    check(nm, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    apply(in_idle());
    #1;
    check("in_reset", O_ZERO);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vec_t tbl[14];
    in_t  x;
    out_t e;

    O_ZERO   = '0;
    O_DEF    = mk(4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    O_LU     = mk(4'hF, 4'h1, 4'h2, 4'h0, 1, 0, 0, 0);
    O_BR     = mk(4'hF, 4'h0, 4'h3, 4'h0, 0, 1, 0, 0);
    O_MW     = mk(4'hF, 4'h7, 4'h8, 4'h0, 1, 0, 0, 0);
    O_DR     = mk(4'hF, 4'h0, 4'h1, 4'h0, 1, 0, 0, 0);
    O_DRBR   = mk(4'hF, 4'h0, 4'h3, 4'h0, 1, 0, 0, 0);
    O_HLT    = mk(4'h0, 4'h0, 4'h0, 4'hF, 1, 0, 1, 0);
    O_HLT_TO = mk(4'h0, 4'h0, 4'h0, 4'hF, 1, 0, 1, 1);

    tbl[0]  = '{in_idle(),    O_DEF, "idle"};
    tbl[1]  = '{in_lu(5, 5),  O_LU,  "lu_rs2"};
    tbl[2]  = '{in_idle(),    O_DEF, "lu_one_cycle"};
    tbl[3]  = '{in_lu(0, 0),  O_DEF, "lu_rd0"};
    x = in_lu(5, 5); x.br = 1'b1;
    tbl[4]  = '{x,            O_BR,  "br_over_lu"};
    x = in_br(); x.ex_valid = 1'b0;
    tbl[5]  = '{x,            O_DEF, "br_unqualified"};
    x = in_lu(7, 0); x.u2 = 1'b0; x.u1 = 1'b1; x.rs1 = 5'd7;
    tbl[6]  = '{x,            O_LU,  "lu_rs1"};
    x.u1 = 1'b0;
    tbl[7]  = '{x,            O_DEF, "lu_src_unused"};
    x = in_lu(5, 5); x.ld = 1'b0;
    tbl[8]  = '{x,            O_DEF, "no_load"};
    tbl[9]  = '{in_mw(),      O_MW,  "mw"};
    x = in_mw(); x.ex_valid = 1'b1; x.br = 1'b1;
    tbl[10] = '{x,            O_MW,  "mw_br_suppressed"};
    x.mrdy = 1'b1;
    tbl[11] = '{x,            O_BR,  "mw_release_br"};
    x = in_lu(5, 5); x.mreq = 1'b1;
    tbl[12] = '{x,            O_MW,  "mw_over_lu"};
    tbl[13] = '{in_idle(),    O_DEF, "mw_release_idle"};

    apply(in_idle());
    #1;
    check("reset_state", O_ZERO);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) cycle(tbl[i].i, tbl[i].o, tbl[i].name);

    // Three-cycle memory wait with a branch waiting behind it.
    do_reset();
    cycle(in_mw(), O_MW, "mw3_c1");
    x = in_mw(); x.ex_valid = 1'b1; x.br = 1'b1;
    cycle(x, O_MW, "mw3_c2");
    cycle(x, O_MW, "mw3_c3");
    x.mrdy = 1'b1;
    cycle(x, O_BR, "mw3_release");
    cycle(in_idle(), O_DEF, "mw3_after");

    // Memory timeout.
    do_reset();
    for (int i = 0; i < int'(TO); i++) cycle(in_mw(), O_MW, $sformatf("to_wait%0d", i));
    cycle(in_br(), O_HLT_TO, "to_halted");
    cycle(in_lu(5, 5), O_HLT_TO, "to_halted_ignores");

    // Orderly halt.
    do_reset();
    cycle(in_halt(), O_DEF, "halt_req");
    for (int i = 0; i < int'(DRAIN); i++) cycle(in_lu(3, 3), O_DR, $sformatf("drain%0d", i));
    cycle(in_br(), O_HLT, "halted");
    cycle(in_mw(), O_HLT, "halted_ignores_mw");

    // Two-cycle memory wait inside the drain window.
    do_reset();
    cycle(in_halt(), O_DEF, "dm_halt_req");
    cycle(in_idle(), O_DR, "dm_d1");
    cycle(in_mw(), O_MW, "dm_w1");
    cycle(in_mw(), O_MW, "dm_w2");
    cycle(in_idle(), O_DR, "dm_d2");
    cycle(in_br(), O_DRBR, "dm_d3_br");
    cycle(in_idle(), O_DR, "dm_d4");
    cycle(in_idle(), O_HLT, "dm_halted");

    // Async reset between clock edges while draining.
    do_reset();
    cycle(in_halt(), O_DEF, "ar_halt_req");
    cycle(in_idle(), O_DR, "ar_d1");
    cycle(in_idle(), O_DR, "ar_d2");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", O_ZERO);
    @(negedge clk);
    reset = 1'b0;
    cycle(in_idle(), O_DEF, "ar_run");
    cycle(in_idle(), O_DEF, "ar_run2");

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 60 == 59) do_reset();
      x = rand_in();
      @(negedge clk);
      apply(x);
      model_step(x, e);
      #1;
      check($sformatf("rand%0d", c), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage in-order pipeline. Drives the stall/branch/halt/enable controls of the four inter-stage pipeline registers: index 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB.
Handles three event types: load-use interlocks, taken-branch flushes and data-memory wait states. Also runs an orderly halt (drain then freeze) and a memory-timeout error halt.

Parameters:
REG_W, 5, register-index width
LOAD_USE_CYCLES, 1, bubble cycles per load-use hazard (>=1)
DRAIN_CYCLES, 4, cycles to drain in-flight instructions before freezing
MEM_TIMEOUT, 255, max consecutive mem-wait cycles before error (>=1)
CNT_W, 8, counter width; must hold max(LOAD_USE_CYCLES, DRAIN_CYCLES, MEM_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  valid instruction in ID (IF/ID output)
id_rs1, id_rs2  in  REG_W  ID source registers
id_uses_rs1, id_uses_rs2  in  1  source actually read
ex_valid  in  1  valid instruction in EX (ID/EX output)
ex_rd  in  REG_W  EX destination register
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  MEM stage has an outstanding data access
mem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  halt request pulse (ecall/debug)
pipe_enable  out  4  enable per pipeline register
pipe_stall  out  4  stall (hold) per pipeline register
pipe_flush  out  4  branch/bubble (valid<=0) per pipeline register
pipe_halt  out  4  halt (clear) per pipeline register
pc_hold  out  1  PC must not advance
pc_redirect  out  1  PC loads branch target
halted  out  1  controller in HALTED
mem_timeout  out  1  sticky timeout error

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT, DRAIN, HALTED. Counter cnt (CNT_W bits), sticky halt_pend, prior state saved for MEM_WAIT return.
- Reset (async, asserted): state=RUN, cnt=0, halt_pend=0, mem_timeout=0. While reset is high every output is 0.
- Outputs are combinational from state and current inputs. An event seen in cycle t is acted on by the registers at the edge ending cycle t.
- Defaults in RUN with no event: pipe_enable=4'b1111, all other outputs 0.
- hazard = ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- memwait = mem_req & ~mem_ready.
- Priority, highest first: memwait > ex_branch_taken (qualified by ex_valid) > hazard > halt_pend.
- memwait, in any state except HALTED:
  - Outputs: pipe_stall=4'b0111, pipe_flush[3]=1, pc_hold=1; the branch redirect is suppressed.
  - Enter MEM_WAIT from RUN, LOAD_STALL or DRAIN, saving the prior state and the frozen cnt; then load cnt=1.
  - In MEM_WAIT, cnt increments each cycle. When cnt reaches MEM_TIMEOUT with no mem_ready: set mem_timeout and go to HALTED.
  - On mem_ready: return to the saved state with its saved cnt; MEM_WAIT outputs are not asserted that cycle.
- Branch, in RUN or LOAD_STALL:
  - Outputs: pipe_flush=4'b0011, pc_redirect=1. Any load-use stall is cancelled; next state RUN.
  - In DRAIN: pipe_flush=4'b0011, pc_redirect=0.
- Load-use, in RUN:
  - Outputs: pipe_stall[0]=1, pipe_flush[1]=1, pc_hold=1.
  - If LOAD_USE_CYCLES>1: enter LOAD_STALL with cnt=LOAD_USE_CYCLES-1. LOAD_STALL repeats the same outputs each cycle, decrements cnt, and returns to RUN when cnt reaches 1.
- halt_req sets halt_pend in any state. In RUN with no higher-priority event and halt_pend=1: enter DRAIN with cnt=DRAIN_CYCLES.
- DRAIN: pc_hold=1, pipe_flush[0]=1 (no new fetches). Load-use detection is disabled. cnt decrements each cycle; at 0, go to HALTED.
- HALTED: pipe_halt=4'b1111, pipe_enable=0, pc_hold=1, halted=1. All inputs are ignored. Exit only via reset.
- Reset mid-operation aborts any state immediately; counters are cleared.

Test Plan:
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5; id_valid=1, id_uses_rs2=1, id_rs2=5 -> same cycle pipe_stall=0001, pipe_flush=0010, pc_hold=1 for exactly 1 cycle. Repeat with ex_rd=0 -> no stall.
- Branch + hazard together: ex_branch_taken=1 with the load-use hazard above -> pipe_flush=0011, pc_redirect=1, pipe_stall=0000.
- Mem wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> pipe_stall=0111, pipe_flush=1000 for 3 cycles, then defaults. Branch present during the wait -> redirect only after release.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 and halted=1 after 4 wait cycles; pipe_halt=1111 afterwards.
- Halt: pulse halt_req in RUN -> pc_hold=1, pipe_flush=0001 for 4 cycles (DRAIN_CYCLES=4), then halted=1. A 2-cycle memwait during DRAIN extends total drain time by 2 cycles.
- Async reset asserted mid-DRAIN, between clock edges -> all outputs 0 immediately; after release, state RUN with pipe_enable=1111.
